// File: rtl/bp_types.sv
// Branch-predictor shared types: init/run FSM states and saturating-counter step.
package bp_types;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } bp_state_e;

    localparam int unsigned CNT_MAX_W = 4;

    // Next value of a width-bit saturating counter (width <= CNT_MAX_W)
    function automatic logic [CNT_MAX_W-1:0] sat_next(
        input logic [CNT_MAX_W-1:0] cnt,
        input logic                 up,
        input int unsigned          width
    );
        logic [CNT_MAX_W-1:0] top;
        top = CNT_MAX_W'((1 << width) - 1);
        if (up) begin
            sat_next = (cnt == top) ? cnt : cnt + CNT_MAX_W'(1);
        end else begin
            sat_next = (cnt == '0) ? cnt : cnt - CNT_MAX_W'(1);
        end
    endfunction

endpackage : bp_types

// File: rtl/rv32i_types.sv
// Shared RV32I scalar types used across the front end.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

endpackage : rv32i_types

// File: rtl/bp_sat_ctr.sv
// Combinational saturating-counter step plus the MSB (prediction) of the current count.
module bp_sat_ctr
    import bp_types::*;
#(
    parameter int unsigned W = 2
) (
    input  logic [W-1:0] cnt_i,
    input  logic         up_i,
    output logic [W-1:0] cnt_next_o,
    output logic         msb_o
);

    assign cnt_next_o = W'(sat_next(CNT_MAX_W'(cnt_i), up_i, W));
    assign msb_o      = cnt_i[W-1];

endmodule : bp_sat_ctr

// File: rtl/local_bp.sv
// Local-history two-level branch predictor with a power-up table sweep.
// Optional same-cycle write-to-read forwarding: define LOCAL_BP_BYPASS_EN.
module local_bp
    import rv32i_types::*;
    import bp_types::*;
#(
    parameter int unsigned S_BHT_IDX   = 10,
    parameter int unsigned S_PC_OFFSET = 2,
    parameter int unsigned S_BHR       = 4,
    parameter int unsigned S_PHT_PC    = 2,
    parameter int unsigned S_CNT       = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      update,
    input  logic      br_en,
    input  rv32i_word raddr,
    input  rv32i_word waddr,
    output logic      br_take,
    output logic      mispred,
    output logic      ready
);

    localparam int unsigned S_PHT_IDX = S_BHR + S_PHT_PC;
    localparam int unsigned S_SWEEP   = (S_BHT_IDX > S_PHT_IDX) ? S_BHT_IDX : S_PHT_IDX;
    localparam int unsigned N_BHT     = 1 << S_BHT_IDX;
    localparam int unsigned N_PHT     = 1 << S_PHT_IDX;
    localparam logic [S_SWEEP-1:0] SWEEP_LAST = '1;
    localparam logic [S_CNT-1:0]   CNT_INIT   = S_CNT'((1 << (S_CNT - 1)) - 1);

    bp_state_e          state_q;
    logic [S_SWEEP-1:0] sweep_q;
    logic               ready_q;

    logic [S_BHR-1:0] bht_q [N_BHT];
    logic [S_CNT-1:0] pht_q [N_PHT];

    logic                 wr_en;
    logic [S_BHT_IDX-1:0] wr_bht_idx;
    logic [S_BHR-1:0]     wr_bhr;
    logic [S_BHR-1:0]     bhr_in;
    logic [S_PHT_IDX-1:0] wr_pht_idx;
    logic [S_CNT-1:0]     wr_cnt;
    logic [S_CNT-1:0]     cnt_next;
    logic                 wr_msb;

    logic [S_BHT_IDX-1:0] rd_bht_idx;
    logic [S_BHR-1:0]     rd_bhr;
    logic [S_PHT_IDX-1:0] rd_pht_idx;
    logic [S_CNT-1:0]     rd_cnt;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{raddr, waddr};

    // Init sweep then run; reset at any time restarts the sweep
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT;
            sweep_q <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    if (sweep_q == SWEEP_LAST) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                    end else begin
                        sweep_q <= sweep_q + S_SWEEP'(1);
                    end
                end
                RUN: begin
                    state_q <= RUN;
                end
                default: begin
                    state_q <= INIT;
                    sweep_q <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign ready = ready_q;
    assign wr_en = update & ready_q;

    // Write path: history shift and counter step for the resolved branch
    assign wr_bht_idx = waddr[S_BHT_IDX+S_PC_OFFSET-1 -: S_BHT_IDX];
    assign wr_bhr     = bht_q[wr_bht_idx];
    assign wr_pht_idx = {wr_bhr, waddr[S_PHT_PC+S_PC_OFFSET-1 -: S_PHT_PC]};
    assign wr_cnt     = pht_q[wr_pht_idx];

    generate
        if (S_BHR == 1) begin : g_bhr_one
            assign bhr_in = br_en;
        end else begin : g_bhr_shift
            assign bhr_in = {wr_bhr[S_BHR-2:0], br_en};
        end
    endgenerate

    bp_sat_ctr #(
        .W(S_CNT)
    ) u_wr_ctr (
        .cnt_i      (wr_cnt),
        .up_i       (br_en),
        .cnt_next_o (cnt_next),
        .msb_o      (wr_msb)
    );

    assign mispred = wr_en & (wr_msb != br_en);

    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            bht_q[S_BHT_IDX'(sweep_q)] <= '0;
            pht_q[S_PHT_IDX'(sweep_q)] <= CNT_INIT;
        end else if (wr_en) begin
            bht_q[wr_bht_idx] <= bhr_in;
            pht_q[wr_pht_idx] <= cnt_next;
        end
    end

    // Read path, optionally forwarding this cycle's write
    assign rd_bht_idx = raddr[S_BHT_IDX+S_PC_OFFSET-1 -: S_BHT_IDX];

    always_comb begin
        rd_bhr = bht_q[rd_bht_idx];
`ifdef LOCAL_BP_BYPASS_EN
        if (wr_en && (rd_bht_idx == wr_bht_idx)) begin
            rd_bhr = bhr_in;
        end
`endif
    end

    assign rd_pht_idx = {rd_bhr, raddr[S_PHT_PC+S_PC_OFFSET-1 -: S_PHT_PC]};

    always_comb begin
        rd_cnt = pht_q[rd_pht_idx];
`ifdef LOCAL_BP_BYPASS_EN
        if (wr_en && (rd_pht_idx == wr_pht_idx)) begin
            rd_cnt = cnt_next;
        end
`endif
    end

    assign br_take = ready_q & rd_cnt[S_CNT-1];

endmodule : local_bp

// File: tb/tb_local_bp.sv
// Directed self-checking bench for local_bp at default parameters.
module tb_local_bp;

    logic        clk;
    logic        rst;
    logic        update;
    logic        br_en;
    logic [31:0] raddr;
    logic [31:0] waddr;
    logic        br_take;
    logic        mispred;
    logic        ready;

    int checks   = 0;
    int failures = 0;

    local_bp dut (
        .clk     (clk),
        .rst     (rst),
        .update  (update),
        .br_en   (br_en),
        .raddr   (raddr),
        .waddr   (waddr),
        .br_take (br_take),
        .mispred (mispred),
        .ready   (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Count not-ready samples until ready, bounded
    task automatic wait_ready(input string tag);
        int n;
        int bad_bt;
        int bad_mis;
        n = 0;
        bad_bt = 0;
        bad_mis = 0;
        while (ready !== 1'b1 && n < 2000) begin
            if (br_take !== 1'b0) bad_bt++;
            if (mispred !== 1'b0) bad_mis++;
            n++;
            @(posedge clk);
            #1;
        end
        chk({tag, "_latency"}, n, 1024);
        chk({tag, "_br_take_init"}, bad_bt, 0);
        chk({tag, "_mispred_init"}, bad_mis, 0);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic do_update(input logic [31:0] a, input logic en, input logic exp_mis,
                             input string tag);
        waddr  = a;
        br_en  = en;
        update = 1'b1;
        #1 chk(tag, mispred, exp_mis);
        @(posedge clk);
        #1 update = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        update = 1'b0;
        br_en  = 1'b0;
        raddr  = 32'h0;
        waddr  = 32'h0;

        #2;
        chk("reset_ready", ready, 1'b0);
        chk("reset_br_take", br_take, 1'b0);

        // Power-up sweep with an update held at 0x100 that must be ignored
        @(posedge clk);
        #1 rst = 1'b0;
        update = 1'b1;
        waddr  = 32'h100;
        br_en  = 1'b1;
        wait_ready("sweep0");
        update = 1'b0;
        chk("ready_after_sweep0", ready, 1'b1);

        raddr = 32'h100;
        #1;
        chk("br_take_0x100_fresh", br_take, 1'b0);
        chk("bhr_0x100_fresh", 32'(dut.bht_q[64]), 32'h0);
        raddr = 32'h0;
        @(posedge clk);
        #1;

        // Eight taken updates at 0x100
        for (int i = 0; i < 8; i++) begin
            do_update(32'h100, 1'b1, (i < 5), $sformatf("mispred_0x100_u%0d", i + 1));
        end
        raddr = 32'h100;
        #1;
        chk("br_take_0x100_trained", br_take, 1'b1);
        chk("pht_h1111_saturated", 32'(dut.pht_q[60]), 32'd3);
        chk("bhr_0x100_trained", 32'(dut.bht_q[64]), 32'hF);

        // Reset mid-sweep at index 500
        @(posedge clk);
        #1;
        pulse_rst();
        repeat (500) @(posedge clk);
        #1 rst = 1'b1;
        #1 chk("midsweep_ready_in_rst", ready, 1'b0);
        #1 rst = 1'b0;
        wait_ready("sweep1");
        chk("ready_after_sweep1", ready, 1'b1);

        // Alternating T/N at 0x300
        raddr = 32'h0;
        for (int i = 0; i < 10; i++) begin
            do_update(32'h300, (i % 2 == 0), (i < 5) && (i % 2 == 0),
                      $sformatf("mispred_0x300_u%0d", i + 1));
        end
        raddr = 32'h300;
        #1 chk("br_take_0x300_next_taken", br_take, 1'b1);
        chk("bhr_0x300", 32'(dut.bht_q[192]), 32'hA);
        raddr = 32'h304;
        #1 chk("br_take_0x304_untouched", br_take, 1'b0);
        chk("bhr_0x304_untouched", 32'(dut.bht_q[193]), 32'h0);

        // Fresh tables, then same-cycle forwarding at 0x200
        @(posedge clk);
        #1;
        pulse_rst();
        wait_ready("sweep2");
        raddr = 32'h0;
        do_update(32'h210, 1'b1, 1'b1, "mispred_0x210_u1");
        do_update(32'h210, 1'b1, 1'b1, "mispred_0x210_u2");
        do_update(32'h220, 1'b0, 1'b1, "mispred_0x220_u1");
        raddr = 32'h200;
        #1 chk("br_take_0x200_h0000", br_take, 1'b0);

        waddr  = 32'h200;
        br_en  = 1'b1;
        update = 1'b1;
        #1;
`ifdef LOCAL_BP_BYPASS_EN
        chk("br_take_0x200_same_cycle", br_take, 1'b1);
`else
        chk("br_take_0x200_same_cycle", br_take, 1'b0);
`endif
        chk("mispred_0x200", mispred, 1'b1);
        @(posedge clk);
        #1 update = 1'b0;
        #1 chk("br_take_0x200_h0001", br_take, 1'b1);
        chk("bhr_0x200", 32'(dut.bht_q[128]), 32'h1);
        chk("mispred_idle", mispred, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_local_bp

// File: doc/local_bp.md
LOCAL_BP -- requirements
Module: local_bp

Interface
REQ-001 SHALL have parameter S_BHT_IDX, default 10, meaning log2 of the number of BHT (history register) entries.
REQ-002 SHALL have parameter S_PC_OFFSET, default 2, meaning the low PC bits dropped before indexing.
REQ-003 SHALL have parameter S_BHR, default 4 (legal 1..12), meaning the history length in bits per BHT entry.
REQ-004 SHALL have parameter S_PHT_PC, default 2, meaning the number of PC bits concatenated into the PHT index.
REQ-005 SHALL have parameter S_CNT, default 2 (legal 1..4), meaning the saturating counter width.
REQ-006 SHALL have port clk, input, 1 bit: the single clock, all state on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have port update, input, 1 bit: a resolved branch is presented this cycle.
REQ-009 SHALL have port br_en, input, 1 bit: the resolved outcome (1 = taken).
REQ-010 SHALL have port raddr, input, rv32i_word: the PC being predicted.
REQ-011 SHALL have port waddr, input, rv32i_word: the PC of the resolved branch.
REQ-012 SHALL have port br_take, output, 1 bit: the prediction for raddr.
REQ-013 SHALL have port mispred, output, 1 bit: the resolved branch disagreed with the stored prediction.
REQ-014 SHALL have port ready, output, 1 bit: tables are initialised and the predictor is live.

Function
REQ-015 SHALL derive the BHT index as addr[S_BHT_IDX+S_PC_OFFSET-1:S_PC_OFFSET].
REQ-016 SHALL derive the PHT index as {bhr, addr[S_PHT_PC+S_PC_OFFSET-1:S_PC_OFFSET]}, giving 2^(S_BHR+S_PHT_PC) counters.
REQ-017 SHALL drive br_take combinationally as the counter MSB for raddr when ready=1, and 0 when ready=0.
REQ-018 SHALL, on update with ready=1, write bhr_in = {old bhr[S_BHR-2:0], br_en} (or br_en alone if S_BHR=1) to the BHT entry of waddr.
REQ-019 SHALL, on the same update, write the PHT counter indexed with the old bhr: increment if br_en, decrement otherwise, saturating at 0 and 2^S_CNT-1.
REQ-020 SHALL assert mispred combinationally in the update cycle iff update & ready & (old counter MSB != br_en); otherwise mispred=0.
REQ-021 SHALL implement an FSM with states INIT and RUN; INIT sweeps a counter from 0 to 2^max(S_BHT_IDX, S_BHR+S_PHT_PC)-1, writing one BHT and one PHT entry per cycle (index masked to each table's width).
REQ-022 SHALL transition INIT to RUN on the cycle after the last sweep index; ready=1 only in RUN.
REQ-023 SHALL ignore update during INIT: no table write and mispred=0.
REQ-024 SHALL restart the sweep from index 0 if rst is asserted mid-sweep or during RUN.

Reset
REQ-025 SHALL, on rst, asynchronously enter INIT with sweep counter 0, ready=0 and br_take=0.
REQ-026 SHALL initialise each counter to weakly-not-taken, 2^(S_CNT-1)-1 (0 when S_CNT=1), and each BHR to all-zeros.

Configuration
REQ-027 SHALL, with LOCAL_BP_BYPASS_EN defined, forward in the same cycle: if update & ready and the BHT indices of raddr and waddr match, the read bhr is bhr_in; if the resolved PHT index also equals the read PHT index, br_take uses the new counter.
REQ-028 SHALL, without LOCAL_BP_BYPASS_EN, read registered table contents only, so a write becomes visible from the next cycle.

Structure
REQ-029 SHALL take rv32i_word from rv32i_types, and SHALL place the FSM state enum (INIT, RUN) and a saturating-counter next-value function in a shared package bp_types.
REQ-030 SHALL contain exactly one sub-module, bp_sat_ctr (combinational next-count and MSB), instantiated once for the write path.

Verification (defaults, bypass enabled)
REQ-031 SHALL check: rst pulse, then count cycles -> ready=0 and br_take=0 for exactly 1024 cycles, ready=1 on cycle 1025.
REQ-032 SHALL check: update at waddr=0x100 during INIT -> mispred=0; after ready, raddr=0x100 -> br_take=0 and BHR=0000.
REQ-033 SHALL check: 8 taken updates at 0x100 -> mispred=1 on updates 1-5 (fresh counters at histories 0000/0001/0011/0111/1111, then 1111 -> counter 2), 0 on 6-8; br_take(0x100)=1 and counter at history 1111 saturated at 3.
REQ-034 SHALL check: raddr=waddr=0x200, history 0000, update br_en=1 -> br_take reflects history 0001 in the same cycle; without the macro, it reflects history 0000.
REQ-035 SHALL check: 10 alternating T/N updates at 0x300 -> the predictions track the pattern after warm-up, and 0x304 (other BHT entry) is unaffected.
REQ-036 SHALL check: rst asserted mid-sweep at index 500 -> ready stays 0 for a further full 1024 cycles.
